// File: rtl/morse_pkg.sv
// Shared definitions for the Morse send path: symbol codes, FSM states and
// the compact length/pattern encoding of one Morse symbol.
package morse_pkg;

  localparam logic [5:0] SYM_0 = 6'd0,  SYM_1 = 6'd1,  SYM_2 = 6'd2,  SYM_3 = 6'd3;
  localparam logic [5:0] SYM_4 = 6'd4,  SYM_5 = 6'd5,  SYM_6 = 6'd6,  SYM_7 = 6'd7;
  localparam logic [5:0] SYM_8 = 6'd8,  SYM_9 = 6'd9,  SYM_A = 6'd10, SYM_B = 6'd11;
  localparam logic [5:0] SYM_C = 6'd12, SYM_D = 6'd13, SYM_E = 6'd14, SYM_F = 6'd15;
  localparam logic [5:0] SYM_G = 6'd16, SYM_H = 6'd17, SYM_I = 6'd18, SYM_J = 6'd19;
  localparam logic [5:0] SYM_K = 6'd20, SYM_L = 6'd21, SYM_M = 6'd22, SYM_N = 6'd23;
  localparam logic [5:0] SYM_O = 6'd24, SYM_P = 6'd25, SYM_Q = 6'd26, SYM_R = 6'd27;
  localparam logic [5:0] SYM_S = 6'd28, SYM_T = 6'd29, SYM_U = 6'd30, SYM_V = 6'd31;
  localparam logic [5:0] SYM_W = 6'd32, SYM_X = 6'd33, SYM_Y = 6'd34, SYM_Z = 6'd35;
  localparam logic [5:0] SYM_MAX = 6'd35;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

  // pat is read MSB-first from pat[len-1]; 1 = dash, 0 = dot
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } morse_t;

endpackage

// File: rtl/morse_rom.sv
// Combinational symbol code to ITU Morse lookup; unknown codes give len=0.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] symbol,
  output morse_t     code
);

  always_comb begin
    code = '{len: 3'd0, pat: 5'd0};
    case (symbol)
      SYM_0: code = '{3'd5, 5'b11111};
      SYM_1: code = '{3'd5, 5'b01111};
      SYM_2: code = '{3'd5, 5'b00111};
      SYM_3: code = '{3'd5, 5'b00011};
      SYM_4: code = '{3'd5, 5'b00001};
      SYM_5: code = '{3'd5, 5'b00000};
      SYM_6: code = '{3'd5, 5'b10000};
      SYM_7: code = '{3'd5, 5'b11000};
      SYM_8: code = '{3'd5, 5'b11100};
      SYM_9: code = '{3'd5, 5'b11110};
      SYM_A: code = '{3'd2, 5'b00001};
      SYM_B: code = '{3'd4, 5'b01000};
      SYM_C: code = '{3'd4, 5'b01010};
      SYM_D: code = '{3'd3, 5'b00100};
      SYM_E: code = '{3'd1, 5'b00000};
      SYM_F: code = '{3'd4, 5'b00010};
      SYM_G: code = '{3'd3, 5'b00110};
      SYM_H: code = '{3'd4, 5'b00000};
      SYM_I: code = '{3'd2, 5'b00000};
      SYM_J: code = '{3'd4, 5'b00111};
      SYM_K: code = '{3'd3, 5'b00101};
      SYM_L: code = '{3'd4, 5'b00100};
      SYM_M: code = '{3'd2, 5'b00011};
      SYM_N: code = '{3'd2, 5'b00010};
      SYM_O: code = '{3'd3, 5'b00111};
      SYM_P: code = '{3'd4, 5'b00110};
      SYM_Q: code = '{3'd4, 5'b01101};
      SYM_R: code = '{3'd3, 5'b00010};
      SYM_S: code = '{3'd3, 5'b00000};
      SYM_T: code = '{3'd1, 5'b00001};
      SYM_U: code = '{3'd3, 5'b00001};
      SYM_V: code = '{3'd4, 5'b00001};
      SYM_W: code = '{3'd3, 5'b00011};
      SYM_X: code = '{3'd4, 5'b01001};
      SYM_Y: code = '{3'd4, 5'b01011};
      SYM_Z: code = '{3'd4, 5'b01100};
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts a symbol code over valid/ready and keys it out
// with unit-based ITU timing; sym_out shows the symbol being sent.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] symbol,
  input  logic       valid,
  output logic       ready,
  output logic       key,
  output logic       done,
  output logic       err,
  output logic [5:0] sym_out
);

  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [2:0]    idx, next_idx;
  logic [4:0]    pat, next_pat;
  logic [2:0]    first_idx;
  logic          next_done;
  logic          accept, reject;
  morse_t        rom_code;

  morse_rom u_rom (
    .symbol (symbol),
    .code   (rom_code)
  );

  assign accept    = valid && ready && (symbol <= SYM_MAX);
  assign reject    = valid && ready && (symbol > SYM_MAX);
  assign first_idx = rom_code.len - 3'd1;

  // Counter counts down from duration-1 and is reloaded on every state entry
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = idx;
    next_pat   = pat;
    next_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = MARK;
          next_pat   = rom_code.pat;
          next_idx   = first_idx;
          next_cnt   = rom_code.pat[first_idx] ? T3 : T1;
        end
      end
      MARK: begin
        if (cnt == '0) begin
          if (idx == 3'd0) begin
            next_state = LGAP;
            next_cnt   = T3;
          end else begin
            next_state = SPACE;
            next_cnt   = T1;
          end
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      SPACE: begin
        if (cnt == '0) begin
          next_state = MARK;
          next_idx   = idx - 3'd1;
          next_cnt   = pat[idx - 3'd1] ? T3 : T1;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      LGAP: begin
        if (cnt == '0) begin
          next_state = IDLE;
          next_cnt   = '0;
          next_done  = 1'b1;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      pat     <= 5'd0;
      key     <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      sym_out <= 6'h3F;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      idx   <= next_idx;
      pat   <= next_pat;
      key   <= (next_state == MARK);
      ready <= (next_state == IDLE);
      done  <= next_done;
      err   <= reject;
      if (accept) sym_out <= symbol;
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with a done-driven scoreboard that decodes
// the observed key marks against an ITU string table.
module tb_morse_tx;

  localparam int UNIT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] symbol = 6'd0;
  logic       valid = 1'b0;
  logic       ready, key, done, err;
  logic [5:0] sym_out;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int done_cnt = 0;
  logic [5:0] sb [$];

  morse_tx #(.UNIT_CYCLES(UNIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .symbol  (symbol),
    .valid   (valid),
    .ready   (ready),
    .key     (key),
    .done    (done),
    .err     (err),
    .sym_out (sym_out)
  );

  always #5 clk = ~clk;

  function automatic string itu(input int s);
    case (s)
      0: return "-----";  1: return ".----";  2: return "..---";  3: return "...--";
      4: return "....-";  5: return ".....";  6: return "-....";  7: return "--...";
      8: return "---..";  9: return "----.";  10: return ".-";    11: return "-...";
      12: return "-.-.";  13: return "-..";   14: return ".";     15: return "..-.";
      16: return "--.";   17: return "....";  18: return "..";    19: return ".---";
      20: return "-.-";   21: return ".-..";  22: return "--";    23: return "-.";
      24: return "---";   25: return ".--.";  26: return "--.-";  27: return ".-.";
      28: return "...";   29: return "-";     30: return "..-";   31: return "...-";
      32: return ".--";   33: return "-..-";  34: return "-.--";  35: return "--..";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a valid symbol for one cycle from an idle sample point
  task automatic send(input logic [5:0] s);
    symbol = s;
    valid  = 1'b1;
    if (s <= 6'd35) begin
      sb.push_back(s);
      accepted++;
    end
    step;
    valid = 1'b0;
  endtask

  // Called one cycle after the accepting edge; ends on the done cycle
  task automatic check_trace(input int s);
    string p;
    p = itu(s);
    for (int i = 0; i < p.len(); i++) begin
      int m;
      m = (p[i] == "-") ? 3 * UNIT : UNIT;
      for (int k = 0; k < m; k++) begin
        chk($sformatf("key_mark_s%0d_e%0d", s, i), key, 1);
        chk("ready_busy", ready, 0);
        chk("done_busy", done, 0);
        step;
      end
      if (i != p.len() - 1) begin
        for (int k = 0; k < UNIT; k++) begin
          chk($sformatf("key_space_s%0d_e%0d", s, i), key, 0);
          chk("ready_busy", ready, 0);
          step;
        end
      end
    end
    for (int k = 0; k < 3 * UNIT; k++) begin
      chk($sformatf("key_lgap_s%0d", s), key, 0);
      chk("done_lgap", done, 0);
      step;
    end
    chk($sformatf("done_pulse_s%0d", s), done, 1);
    chk($sformatf("ready_at_done_s%0d", s), ready, 1);
    chk($sformatf("sym_out_s%0d", s), sym_out, 32'(s));
  endtask

  // Scoreboard side: decode mark lengths and pop the expected symbol on done
  initial begin
    string rec;
    int run;
    logic [5:0] exp_sym;
    rec = "";
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rec = "";
        run = 0;
      end else begin
        if (key) run++;
        else if (run > 0) begin
          rec = {rec, (run == 3 * UNIT) ? "-" : (run == UNIT) ? "." : "?"};
          run = 0;
        end
        if (done) begin
          done_cnt++;
          chk("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_sym = sb.pop_front();
            chk("sb_sym_out", sym_out, 32'(exp_sym));
            checks++;
            assert (rec == itu(int'(exp_sym))) else begin
              errors++;
              $error("FAIL sb_marks_s%0d: observed %s expected %s", exp_sym, rec, itu(int'(exp_sym)));
            end
          end
          rec = "";
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_key", key, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sym_out", sym_out, 63);
    reset_n = 1'b1;
    step;

    // Out-of-range code
    send(6'd36);
    chk("err_pulse", err, 1);
    chk("err_key", key, 0);
    chk("err_ready", ready, 1);
    chk("err_sym_out", sym_out, 63);
    step;
    chk("err_one_cycle", err, 0);
    chk("err_ready_after", ready, 1);

    // E and '0'
    send(6'd14);
    check_trace(14);
    step;
    send(6'd0);
    check_trace(0);
    step;

    // K with T held on valid throughout; T only taken on the done cycle
    send(6'd20);
    symbol = 6'd29;
    valid  = 1'b1;
    check_trace(20);
    sb.push_back(6'd29);
    accepted++;
    step;
    valid = 1'b0;
    chk("t_sym_out", sym_out, 29);
    check_trace(29);
    step;

    // Reset in the middle of A's dash
    send(6'd10);
    repeat (9) step;
    chk("a_mid_dash_key", key, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_key", key, 0);
    chk("abort_ready", ready, 1);
    chk("abort_sym_out", sym_out, 63);
    chk("abort_done", done, 0);
    sb.delete();
    accepted--;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    step;
    chk("post_abort_done", done, 0);
    chk("post_abort_ready", ready, 1);
    send(6'd14);
    check_trace(14);
    step;

    // Back-to-back sweep of every valid code
    for (int s = 0; s < 36; s++) begin
      symbol = 6'(s);
      valid  = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
        step;
        n++;
      end
      chk($sformatf("sweep_ready_s%0d", s), ready, 1);
      sb.push_back(6'(s));
      accepted++;
      step;
    end
    valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step;
      n++;
    end
    step;
    chk("sb_drained", 32'(sb.size()), 0);
    chk("done_count", 32'(done_cnt), 32'(accepted));
    chk("final_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
